usbfs_serial_echo_buffer: RTL



---
 rtl/usbfs_serial_echo_buffer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/usbfs_serial_echo_buffer.sv
// Burst-releasing echo FIFO between usbfsSerial host-to-device and device-to-host streams.
// Define USBFS_ECHO_CASEFLIP_EN to flip the case of ASCII letters on the way out.
//
// state | meaning
// FILL  | collecting bytes; watching terminator, fill threshold, idle timeout, pending flush
// DRAIN | releasing only the bytes present at entry; new bytes are still accepted
module usbfs_serial_echo_buffer #(
  parameter int DEPTH           = 16,
  parameter int FLUSH_THRESHOLD = 8,
  parameter int IDLE_TIMEOUT    = 48000
) (
  input  logic                       i_clk_48MHz,
  input  logic                       i_rst_n,
  input  logic [7:0]                 i_hostToDev_data,
  input  logic                       i_hostToDev_valid,
  output logic                       o_hostToDev_ready,
  output logic [7:0]                 o_devToHost_data,
  output logic                       o_devToHost_valid,
  input  logic                       i_devToHost_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_draining
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(IDLE_TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C    = CW'(FLUSH_THRESHOLD);
  localparam logic [TW-1:0] TIMER_MAX_C = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   drain_rem_q, drain_rem_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            pend_q, pend_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      head;
  logic            push, pop, is_term;

  assign o_hostToDev_ready = (count_q < DEPTH_C);
  assign o_devToHost_valid = (state_q == DRAIN) && (drain_rem_q != '0);
  assign push    = i_hostToDev_valid && o_hostToDev_ready;
  assign pop     = o_devToHost_valid && i_devToHost_ready;
  assign is_term = (i_hostToDev_data == 8'h0D) || (i_hostToDev_data == 8'h0A);
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

  assign head = mem_q[rd_ptr_q];
`ifdef USBFS_ECHO_CASEFLIP_EN
  assign o_devToHost_data = ((head >= 8'h41 && head <= 8'h5A) || (head >= 8'h61 && head <= 8'h7A))
                            ? (head ^ 8'h20) : head;
`else
  assign o_devToHost_data = head;
`endif

  assign o_count    = count_q;
  assign o_draining = (state_q == DRAIN);

  always_comb begin
    state_d     = state_q;
    drain_rem_d = drain_rem_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    case (state_q)
      FILL: begin
        if (push || count_q == '0) begin
          timer_d = '0;
        end else if (timer_q != TIMER_MAX_C) begin
          timer_d = timer_q + TW'(1);
        end
        if ((push && is_term) || (count_d >= THRESH_C) ||
            ((count_q != '0) && ((timer_q == TIMER_MAX_C) || pend_q))) begin
          state_d     = DRAIN;
          drain_rem_d = count_d;
          pend_d      = 1'b0;
        end
      end
      DRAIN: begin
        timer_d = '0;
        if (push && is_term) begin
          pend_d = 1'b1;
        end
        if (pop) begin
          drain_rem_d = drain_rem_q - CW'(1);
        end
        // Leave on the edge of the last pop so FILL can re-trigger one edge later
        if (drain_rem_d == '0) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= FILL;
      count_q     <= '0;
      drain_rem_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      timer_q     <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      drain_rem_q <= drain_rem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid
  always_ff @(posedge i_clk_48MHz) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_hostToDev_data;
    end
  end

endmodule
